// File: rtl/timer_control.sv
// Cook-timer control: holds the MM:SS BCD program and sequences the countdown block.
// Optional alarm auto-clear is built when ALARM_TIMEOUT_EN is defined.
module timer_control #(
  parameter int unsigned TICK_CYCLES   = 100_000_000,
  parameter int unsigned ALARM_SECONDS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_sec,
  input  logic       btn_inc_min,
  input  logic       done,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       load,
  output logic       count_enable,
  output logic       main_enable,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int unsigned TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tick_cnt;
  logic          tick_last;
  logic          prog_zero;
  logic          timeout_hit;

  // Only the highest-priority button of a cycle is allowed to act.
  logic do_clear;
  logic do_start;
  logic do_inc_min;
  logic do_inc_sec;

  assign do_clear   = btn_clear;
  assign do_start   = btn_start & ~btn_clear;
  assign do_inc_min = btn_inc_min & ~btn_clear & ~btn_start;
  assign do_inc_sec = btn_inc_sec & ~btn_clear & ~btn_start & ~btn_inc_min;

  assign tick_last = (tick_cnt == TICK_LAST);
  assign prog_zero = (seconds_prog == 4'd0) && (tens_seconds_prog == 4'd0) &&
                     (minutes_prog == 4'd0) && (tens_minutes_prog == 4'd0);

`ifdef ALARM_TIMEOUT_EN
  localparam int unsigned AW = (ALARM_SECONDS > 1) ? $clog2(ALARM_SECONDS + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECONDS - 1);

  logic [AW-1:0] alarm_cnt;

  assign timeout_hit = (state_q == ALARM) && tick_last && (alarm_cnt == ALARM_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_cnt <= '0;
    end else if (state_q != ALARM) begin
      alarm_cnt <= '0;
    end else if (tick_last) begin
      alarm_cnt <= alarm_cnt + AW'(1);
    end
  end
`else
  logic unused_alarm_seconds;
  assign unused_alarm_seconds = (ALARM_SECONDS != 0);
  assign timeout_hit          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (do_start && !prog_zero) state_d = RUN;
      end
      RUN: begin
        if (do_clear)      state_d = IDLE;
        else if (do_start) state_d = PAUSE;
        else if (done)     state_d = ALARM;
      end
      PAUSE: begin
        if (do_clear)      state_d = IDLE;
        else if (do_start) state_d = RUN;
      end
      ALARM: begin
        if (do_clear || do_start || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state        = state_q;
  assign load         = (state_q == IDLE);
  assign main_enable  = (state_q == RUN);
  assign alarm        = (state_q == ALARM);
  // Suppressing the tick on done keeps the counter from wrapping past 00:00.
  assign count_enable = (state_q == RUN) && tick_last && !done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Tick divider: restarts from zero out of IDLE, frozen in PAUSE so a partial second survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: tick_cnt <= '0;
        RUN: begin
`ifdef ALARM_TIMEOUT_EN
          if (state_d == ALARM) tick_cnt <= '0;
          else
`endif
          tick_cnt <= tick_last ? '0 : tick_cnt + TW'(1);
        end
`ifdef ALARM_TIMEOUT_EN
        ALARM: tick_cnt <= tick_last ? '0 : tick_cnt + TW'(1);
`endif
        default: tick_cnt <= tick_cnt;
      endcase
    end
  end

  // Program digits are only editable in IDLE; the two fields never carry into each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      seconds_prog      <= 4'd0;
      tens_seconds_prog <= 4'd0;
      minutes_prog      <= 4'd0;
      tens_minutes_prog <= 4'd0;
    end else if (state_q == IDLE) begin
      if (do_clear) begin
        seconds_prog      <= 4'd0;
        tens_seconds_prog <= 4'd0;
        minutes_prog      <= 4'd0;
        tens_minutes_prog <= 4'd0;
      end else if (do_inc_min) begin
        if (minutes_prog == 4'd9) begin
          minutes_prog      <= 4'd0;
          tens_minutes_prog <= (tens_minutes_prog == 4'd9) ? 4'd0 : tens_minutes_prog + 4'd1;
        end else begin
          minutes_prog <= minutes_prog + 4'd1;
        end
      end else if (do_inc_sec) begin
        if (seconds_prog == 4'd9) begin
          seconds_prog      <= 4'd0;
          tens_seconds_prog <= (tens_seconds_prog == 4'd5) ? 4'd0 : tens_seconds_prog + 4'd1;
        end else begin
          seconds_prog <= seconds_prog + 4'd1;
        end
      end
    end
  end

endmodule
